// File: rtl/stream_mux_rr.sv
// ============================================================================
// stream_mux_rr
//
// N-channel, W-bit stream multiplexer with valid/ready handshaking,
// packet-locked arbitration and a single registered output stage.
//
// Arbitration scans for the next requesting channel in one IDLE cycle. The
// winner then holds the grant until its beat with in_last is accepted, so the
// beats of one packet are never interleaved with another channel's beats.
// There is one bubble cycle between packets.
//
// Build option:
//   STREAM_MUX_FIXED_PRIO_EN  - when defined, arbitration is strict fixed
//                               priority (lowest asserted index wins) and no
//                               round-robin pointer is kept. When undefined
//                               (default), arbitration is round-robin
//                               starting after the last served channel.
//
// Parameters:
//   BUS_WIDTH  data width per channel
//   NUM_CH     number of input channels (2..16)
//   SEL_W      derived channel-index width (not overridable)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    packed channel data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet, qualified by in_valid
//   in_ready   per-channel ready (combinational from state and out_ready)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_last   registered end-of-packet
//   out_sel    channel that produced the current out_data
//   out_ready  downstream ready
// ============================================================================
module stream_mux_rr #(
    parameter  int BUS_WIDTH = 8,
    parameter  int NUM_CH    = 4,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH-1:0]           in_last,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_sel,
    input  logic                        out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     grant_q, grant_d;
`ifndef STREAM_MUX_FIXED_PRIO_EN
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [SEL_W-1:0]     out_sel_q, out_sel_d;

    logic [BUS_WIDTH-1:0] ch_data [NUM_CH];
    logic                 load_en;
    logic                 in_xfer;
    logic                 arb_found;
    logic [SEL_W-1:0]     arb_idx;
    logic [SEL_W-1:0]     arb_cand;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = in_data[i*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    // The output register can accept a beat when empty or draining this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign in_xfer = (state_q == LOCKED) && in_valid[grant_q] && load_en;

    // ------------------------------------------------------------------
    // Arbiter: first requesting channel in scan order.
    // ------------------------------------------------------------------
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef STREAM_MUX_FIXED_PRIO_EN
            arb_cand = SEL_W'(k);
`else
            // Start just after the last served channel, wrapping at NUM_CH.
            arb_cand = SEL_W'((32'(rr_ptr_q) + 32'd1 + 32'(k)) % 32'(NUM_CH));
`endif
            if (!arb_found && in_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register (with grant, pointer and output register)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
`ifndef STREAM_MUX_FIXED_PRIO_EN
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
`endif
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
`ifndef STREAM_MUX_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
`ifndef STREAM_MUX_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = LOCKED;
                    grant_d = arb_idx;
                end
            end
            LOCKED: begin
                // Grant is released only once the final beat is accepted.
                if (in_xfer && in_last[grant_q]) begin
                    state_d  = IDLE;
`ifndef STREAM_MUX_FIXED_PRIO_EN
                    rr_ptr_d = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (ready back to the granted producer)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = '0;
        if (state_q == LOCKED && load_en) begin
            in_ready[grant_q] = 1'b1;
        end
    end

    // Output register: load on input transfer, otherwise empty on drain.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (in_xfer) begin
            out_data_d  = ch_data[grant_q];
            out_last_d  = in_last[grant_q];
            out_sel_d   = grant_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
